barrett_const_gen: RTL and testbench
====================================

# barrett_const_gen

Sequential generator of the Barrett constant consumed by the 60-by-30 Barrett reducer. It accepts a 30-bit odd modulus and computes floor(2^60 / prime) as a 31-bit value using a one-bit-per-cycle restoring divider. It sits in the parameter-load path: it runs once per modulus change, and its result is registered into the reducer's `barrett_const` input. There is no dependency on host-side precomputation.

## Interface
- No parameters; widths are fixed by the reducer (prime 30 b, constant 31 b).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request pulse; sampled only in IDLE.
- `prime` input 30: modulus; sampled on the accepted `start` cycle.
- `busy` output 1: high while a division is in progress (RUN).
- `done` output 1: one-cycle pulse; `barrett_const` is valid in the same cycle.
- `barrett_const` output 31: floor(2^60 / prime); held until the next accepted `start` or `rst`.
- `err` output 1: invalid-modulus flag, valid with `done` (see Configuration).

## Operation
- FSM states:
  - IDLE:
    - `start`=1 latches `prime` into p_r.
    - Loads remainder R=2^29 (31-bit register), clears the quotient register Q, sets iteration counter cnt=30, and goes to RUN.
  - RUN, one iteration per cycle:
    - T = 2·R (31 bits; no overflow since R < 2^30).
    - If T ≥ p_r: R ← T − p_r and shift 1 into Q (MSB-first). Otherwise R ← T and shift 0 into Q.
    - cnt decrements. The iteration with cnt=0 moves the FSM to DONE.
  - DONE: `done`=1, `barrett_const` ← Q (output register), then IDLE.
- Arithmetic correctness:
  - Long division of 2^60 by p with the 30 leading zero quotient bits skipped. The first iteration compares 2^30 with p, and that quotient bit is always 1 for p < 2^30.
  - The result fits 31 bits for any p > 2^29, which holds for every odd p with bit 29 set.
- Result range: for p ≤ 2^29 the true quotient exceeds 31 bits. The output is then the low 31 bits and is undefined for system use; see the macro.
- `start` while busy or in DONE is ignored; it is neither queued nor restarting.
- Changes to `prime` after acceptance have no effect on the running division.
- Final remainder R is internal only, not output.

## Timing
- Accepted `start` in cycle k:
  - `busy`=1 in cycles k+1 … k+31 (31 iterations).
  - `done`=1 and new `barrett_const` visible in cycle k+32.
  - The FSM is in IDLE at k+33; the earliest next accepted `start` is at k+33.
- Total latency from start to done: 32 cycles; throughput: one constant per 33 cycles.
- Reset values: `busy`=0, `done`=0, `err`=0, `barrett_const`=0, FSM=IDLE.
- `rst` asserted in any state, including mid-RUN, aborts the division and applies the reset values on the next edge. No `done` is produced for the aborted request.
- `rst` and `start` in the same cycle: reset wins, and the start is dropped.

## Configuration
- Macro: `BARRETT_PRIME_CHECK_EN`.
- When defined:
  - On an accepted `start`, the modulus is checked for prime[0]=1 and prime[29]=1.
  - On failure, the FSM goes directly to DONE: `done`=1 at k+1, `err`=1, and `barrett_const`=0.
  - `err` is held until the next accepted `start` or `rst`.
  - A valid modulus follows the normal 32-cycle path with `err`=0.
- When not defined:
  - No check is performed; `err` is tied to 0.
  - Every modulus takes the 32-cycle path, and results for p ≤ 2^29 are truncated as described in Operation.

## Test plan
- prime=0x3FFFFFFF, start at cycle k -> `done` at k+32, barrett_const=0x40000001, `err`=0, `busy` high exactly 31 cycles.
- prime=0x3FFC0001 -> barrett_const=0x4004003F; prime=0x20000001 -> 0x7FFFFFFC, issued back-to-back at the earliest legal start.
- `start` pulsed again at k+10 with a different prime -> ignored; result matches the first prime, with a single `done` pulse.
- `rst` at k+15 mid-RUN -> at k+16 `busy`=0, `done`=0, barrett_const=0; no `done` ever appears for that request, and a new start afterwards completes normally.
- With `BARRETT_PRIME_CHECK_EN`: prime=0x3FFFFFFE (even) or 0x1FFFFFFF (bit 29 clear) -> `done` at k+1, `err`=1, barrett_const=0. The following valid prime=0x3FFFFFFF clears `err` and yields 0x40000001.
- Random sweep of 1000 odd p in (2^29, 2^30) -> each barrett_const equals the reference floor(2^60/p). Each constant, fed into the reducer, gives a correct a mod p for random 60-bit a < p^2.

Source files
------------

// File: rtl/barrett_const_if.sv
// ============================================================================
// Module  : barrett_const_if
// Brief   : Request/result bundle between the parameter loader and the
//           Barrett constant generator.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface barrett_const_if;
   logic        start;
   logic [29:0] prime;
   logic        busy;
   logic        done;
   logic [30:0] barrett_const;
   logic        err;

   modport master (
      output start, prime,
      input  busy, done, barrett_const, err
   );

   modport slave (
      input  start, prime,
      output busy, done, barrett_const, err
   );
endinterface

`default_nettype wire

// File: rtl/barrett_const_gen.sv
// ============================================================================
// Module  : barrett_const_gen
// Brief   : Computes floor(2^60 / prime) for a 30-bit odd modulus with a
//           one-bit-per-cycle restoring divider (31 iterations).
//           Optional modulus check enabled by macro BARRETT_PRIME_CHECK_EN.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module barrett_const_gen (
   input  wire logic      clk,
   input  wire logic      rst,
   barrett_const_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [29:0] r_prime;
   logic [30:0] r_rem;
   logic [29:0] r_quo;   // final quotient bit goes straight into r_const
   logic [4:0]  r_cnt;
   logic [30:0] r_const;
   logic        r_err;

   logic        w_accept;
   logic        w_invalid;
   logic        w_busy;
   logic        w_done;
   logic [30:0] w_twice;
   logic [30:0] w_diff;
   logic        w_ge;

   assign w_accept = (r_state == S_IDLE) && bus.start;

`ifdef BARRETT_PRIME_CHECK_EN
   assign w_invalid = ~(bus.prime[0] & bus.prime[29]);
`else
   assign w_invalid = 1'b0;
`endif

   // Remainder stays below the modulus, so doubling never overflows 31 bits.
   assign w_twice = r_rem << 1;
   assign w_diff  = w_twice - {1'b0, r_prime};
   assign w_ge    = (w_twice >= {1'b0, r_prime});

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_state_nxt = w_invalid ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            w_busy = 1'b1;
            if (r_cnt == 5'd0) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prime <= '0;
         r_rem   <= '0;
         r_quo   <= '0;
         r_cnt   <= '0;
         r_const <= '0;
         r_err   <= 1'b0;
      end else if (w_accept) begin
         // Leading 30 zero quotient bits of 2^60/p are skipped by seeding R=2^29.
         r_prime <= bus.prime;
         r_rem   <= 31'h2000_0000;
         r_quo   <= '0;
         r_cnt   <= 5'd30;
         r_err   <= w_invalid;
         if (w_invalid) begin
            r_const <= '0;
         end
      end else if (r_state == S_RUN) begin
         r_rem <= w_ge ? w_diff : w_twice;
         r_quo <= {r_quo[28:0], w_ge};
         r_cnt <= r_cnt - 5'd1;
         if (r_cnt == 5'd0) begin
            r_const <= {r_quo, w_ge};
         end
      end
   end

   assign bus.busy          = w_busy;
   assign bus.done          = w_done;
   assign bus.barrett_const = r_const;
   assign bus.err           = r_err;

endmodule

`default_nettype wire

// File: tb/tb_barrett_const_gen.sv
// ============================================================================
// Module  : tb_barrett_const_gen
// Brief   : Directed and random checks of barrett_const_gen against an
//           arithmetic reference (64-bit division and a Barrett reduction).
// Rev     : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_barrett_const_gen;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_fail = 0;

   barrett_const_if bif ();

   barrett_const_gen dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   always #5 clk = ~clk;

   int          done_at;
   int          done_cnt;
   int          busy_cnt;
   int          busy_first;
   int          busy_last;
   logic [30:0] res;
   logic        err_seen;
   logic [32:0] snap;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [30:0] ref_const(input logic [29:0] p);
      logic [63:0] num;
      logic [63:0] q;
      num = 64'd1 << 60;
      q   = num / {34'd0, p};
      return q[30:0];
   endfunction

   // Issues one start, then observes 33 cycles (k+1 .. k+33); returns with
   // inputs set for cycle k+33, the earliest legal next start.
   task automatic request(input logic [29:0] p, input int pulse_at,
                          input logic [29:0] p2, input int rst_at);
      done_at = -1; done_cnt = 0; busy_cnt = 0; busy_first = -1; busy_last = -1;
      res = '0; err_seen = 1'b0; snap = '1;
      bif.start = 1'b1;
      bif.prime = p;
      for (int i = 1; i <= 33; i++) begin
         @(posedge clk); #1;
         if (bif.busy) begin
            busy_cnt++;
            if (busy_first < 0) busy_first = i;
            busy_last = i;
         end
         if (bif.done) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at  = i;
               res      = bif.barrett_const;
               err_seen = bif.err;
            end
         end
         if (i == rst_at + 1) snap = {bif.busy, bif.done, bif.barrett_const};
         bif.start = (i == pulse_at);
         bif.prime = (i == pulse_at) ? p2 : 30'($urandom);
         rst       = (i == rst_at);
      end
   endtask

   initial begin
      logic [29:0]  p;
      logic [63:0]  a;
      logic [127:0] prod;
      logic [127:0] q;
      logic [127:0] r;

      bif.start = 1'b0;
      bif.prime = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy",  64'(bif.busy), 64'd0);
      check("reset_done",  64'(bif.done), 64'd0);
      check("reset_err",   64'(bif.err), 64'd0);
      check("reset_const", 64'(bif.barrett_const), 64'd0);

      // start during reset must be dropped
      bif.start = 1'b1;
      bif.prime = 30'h3FFF_FFFF;
      @(posedge clk); #1;
      bif.start = 1'b0;
      rst       = 1'b0;
      @(posedge clk); #1;
      check("rst_start_busy", 64'(bif.busy), 64'd0);

      request(30'h3FFF_FFFF, -1, '0, -1);
      check("c1_done_at",   64'(done_at), 64'd32);
      check("c1_done_cnt",  64'(done_cnt), 64'd1);
      check("c1_busy_cnt",  64'(busy_cnt), 64'd31);
      check("c1_busy_first", 64'(busy_first), 64'd1);
      check("c1_busy_last", 64'(busy_last), 64'd31);
      check("c1_const",     64'(res), 64'h4000_0001);
      check("c1_err",       64'(err_seen), 64'd0);

      request(30'h3FFC_0001, -1, '0, -1);
      check("c2_done_at", 64'(done_at), 64'd32);
      check("c2_const",   64'(res), 64'h4004_003F);
      request(30'h2000_0001, -1, '0, -1);
      check("c3_done_at", 64'(done_at), 64'd32);
      check("c3_const",   64'(res), 64'h7FFF_FFFC);
      check("c3_hold",    64'(bif.barrett_const), 64'h7FFF_FFFC);

      request(30'h3FFF_FFFF, 10, 30'h2000_0001, -1);
      check("ign_done_cnt", 64'(done_cnt), 64'd1);
      check("ign_done_at",  64'(done_at), 64'd32);
      check("ign_const",    64'(res), 64'h4000_0001);

      request(30'h3FFC_0001, -1, '0, 15);
      check("abort_snap",     64'(snap), 64'd0);
      check("abort_done_cnt", 64'(done_cnt), 64'd0);
      check("abort_busy_cnt", 64'(busy_cnt), 64'd15);
      request(30'h3FFC_0001, -1, '0, -1);
      check("after_abort_at",    64'(done_at), 64'd32);
      check("after_abort_const", 64'(res), 64'h4004_003F);

`ifdef BARRETT_PRIME_CHECK_EN
      request(30'h3FFF_FFFE, -1, '0, -1);
      check("even_done_at",  64'(done_at), 64'd1);
      check("even_err",      64'(err_seen), 64'd1);
      check("even_const",    64'(res), 64'd0);
      check("even_busy_cnt", 64'(busy_cnt), 64'd0);
      check("even_err_hold", 64'(bif.err), 64'd1);
      request(30'h1FFF_FFFF, -1, '0, -1);
      check("low_done_at", 64'(done_at), 64'd1);
      check("low_err",     64'(err_seen), 64'd1);
      check("low_const",   64'(res), 64'd0);
      request(30'h3FFF_FFFF, -1, '0, -1);
      check("valid_done_at", 64'(done_at), 64'd32);
      check("valid_err",     64'(err_seen), 64'd0);
      check("valid_const",   64'(res), 64'h4000_0001);
`else
      check("err_tied", 64'(bif.err), 64'd0);
`endif

      for (int n = 0; n < 1000; n++) begin
         p = {1'b1, 28'($urandom), 1'b1};
         request(p, -1, '0, -1);
         check("rnd_done_at", 64'(done_at), 64'd32);
         check("rnd_const",   64'(res), 64'(ref_const(p)));
         check("rnd_err",     64'(err_seen), 64'd0);
         // Barrett reduction of a random a < p^2 using the produced constant
         a    = {$urandom, $urandom} % (64'(p) * 64'(p));
         prod = 128'(a) * 128'(res);
         q    = prod >> 60;
         r    = 128'(a) - q * 128'(p);
         for (int c = 0; c < 3; c++) begin
            if (r >= 128'(p)) r = r - 128'(p);
         end
         check("rnd_reduce", r[63:0], a % 64'(p));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
